axi_port_arbiter: RTL and testbench

- Shares one AXI master engine between NUM_PORTS async-bridge instances.
- Each port has a synced write channel (start/addr/data/done) and a synced read channel (start/addr/done/data).
- Start pulses are latched per source. Grants are round-robin, with one transaction outstanding at a time.
- A watchdog aborts transactions the engine never completes. Sits between the bridge outputs and the AXI master, in the ACLK domain.

---
 rtl/asc_arb_pkg.sv | 22 ++
 rtl/axi_port_arbiter_rr.sv | 33 +++
 rtl/axi_port_arbiter.sv | 201 ++++++++++++++++++++
 tb/tb_axi_port_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/asc_arb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | asc_arb_pkg : shared constants for the AXI port arbiter               |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package asc_arb_pkg;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  // Bit 0 of a source index selects write (even) or read (odd)
  localparam logic SRC_WR = 1'b0;
  localparam logic SRC_RD = 1'b1;

  function automatic int src_idx_w(input int num_ports);
    return (num_ports > 1) ? $clog2(2 * num_ports) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/axi_port_arbiter_rr.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rr_arbiter : combinational round-robin pick starting after last_grant |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int IDX_W = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] last_grant,
  output logic [IDX_W-1:0] grant,
  output logic             any_req
);

  logic [IDX_W-1:0] idx;

  // Scan farthest-first so the closest requester after last_grant is the final winner
  always_comb begin
    grant   = '0;
    any_req = 1'b0;
    idx     = '0;
    for (int i = N_REQ; i >= 1; i--) begin
      idx = IDX_W'((int'(last_grant) + i) % N_REQ);
      if (req[idx]) begin
        grant   = idx;
        any_req = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/axi_port_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | axi_port_arbiter : shares one AXI master engine between bridge ports  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module axi_port_arbiter
  import asc_arb_pkg::*;
#(
  parameter int NUM_PORTS  = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 256,
  parameter int TIMEOUT    = 1024
) (
  input  logic                            ACLK,
  input  logic                            ARESETN,
  input  logic [NUM_PORTS-1:0]            p_wr_start,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0] p_wr_addr,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] p_wr_data,
  output logic [NUM_PORTS-1:0]            p_wr_done,
  input  logic [NUM_PORTS-1:0]            p_rd_start,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0] p_rd_addr,
  output logic [NUM_PORTS-1:0]            p_rd_done,
  output logic [NUM_PORTS*DATA_WIDTH-1:0] p_rd_data,
  output logic                            m_wr_start,
  output logic                            m_rd_start,
  output logic [ADDR_WIDTH-1:0]           m_addr,
  output logic [DATA_WIDTH-1:0]           m_wdata,
  input  logic                            m_wr_done,
  input  logic                            m_rd_done,
  input  logic [DATA_WIDTH-1:0]           m_rd_data,
  output logic                            busy,
  output logic                            err_timeout,
  output logic [NUM_PORTS*2-1:0]          err_overrun
);

  localparam int N_SRC  = 2 * NUM_PORTS;
  localparam int IDX_W  = src_idx_w(NUM_PORTS);
  localparam int PORT_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int CNT_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  logic [1:0]            state_q, state_d;
  logic [N_SRC-1:0]      pending_q, pending_d;
  logic [ADDR_WIDTH-1:0] src_addr_q [N_SRC];
  logic [ADDR_WIDTH-1:0] src_addr_d [N_SRC];
  logic [DATA_WIDTH-1:0] wr_data_q [NUM_PORTS];
  logic [DATA_WIDTH-1:0] wr_data_d [NUM_PORTS];
  logic [DATA_WIDTH-1:0] rd_data_q [NUM_PORTS];
  logic [DATA_WIDTH-1:0] rd_data_d [NUM_PORTS];
  logic [IDX_W-1:0]      grant_q, grant_d;
  logic [IDX_W-1:0]      last_grant_q, last_grant_d;
  logic [CNT_W-1:0]      wd_cnt_q, wd_cnt_d;
  logic [ADDR_WIDTH-1:0] m_addr_q, m_addr_d;
  logic [DATA_WIDTH-1:0] m_wdata_q, m_wdata_d;
  logic                  err_timeout_q, err_timeout_d;
  logic [N_SRC-1:0]      err_overrun_q, err_overrun_d;

  logic [N_SRC-1:0]      w_start;
  logic [ADDR_WIDTH-1:0] w_src_addr [N_SRC];
  logic [IDX_W-1:0]      w_grant;
  logic                  w_any_req;
  logic                  w_take;
  logic                  w_cur_rd;
  logic [PORT_W-1:0]     w_cur_port;
  logic [PORT_W-1:0]     w_gnt_port;
  logic                  w_done;
  logic                  w_timeout;

  generate
    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
      assign w_start[2*p]      = p_wr_start[p];
      assign w_start[2*p+1]    = p_rd_start[p];
      assign w_src_addr[2*p]   = p_wr_addr[p*ADDR_WIDTH +: ADDR_WIDTH];
      assign w_src_addr[2*p+1] = p_rd_addr[p*ADDR_WIDTH +: ADDR_WIDTH];
      assign p_rd_data[p*DATA_WIDTH +: DATA_WIDTH] = rd_data_q[p];
    end
  endgenerate

  rr_arbiter #(
    .N_REQ (N_SRC),
    .IDX_W (IDX_W)
  ) u_rr (
    .req        (pending_q),
    .last_grant (last_grant_q),
    .grant      (w_grant),
    .any_req    (w_any_req)
  );

  assign w_take     = (state_q == IDLE) && w_any_req;
  assign w_cur_rd   = (grant_q[0] == SRC_RD);
  assign w_cur_port = PORT_W'(grant_q >> 1);
  assign w_gnt_port = PORT_W'(w_grant >> 1);
  assign w_done     = w_cur_rd ? m_rd_done : m_wr_done;
  assign w_timeout  = (TIMEOUT != 0) && (wd_cnt_q == CNT_LAST);

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // A done arriving in the ISSUE cycle is honoured for zero-latency engines
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (w_any_req) state_d = ISSUE;
      ISSUE:   state_d = w_done ? RESP : WAIT;
      WAIT:    if (w_done || w_timeout) state_d = RESP;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    m_wr_start = (state_q == ISSUE) && !w_cur_rd;
    m_rd_start = (state_q == ISSUE) &&  w_cur_rd;
    busy       = (state_q != IDLE);
    p_wr_done  = '0;
    p_rd_done  = '0;
    if (state_q == RESP) begin
      if (w_cur_rd) p_rd_done[w_cur_port] = 1'b1;
      else          p_wr_done[w_cur_port] = 1'b1;
    end
  end

  always_comb begin
    pending_d     = pending_q;
    src_addr_d    = src_addr_q;
    wr_data_d     = wr_data_q;
    rd_data_d     = rd_data_q;
    grant_d       = grant_q;
    last_grant_d  = last_grant_q;
    wd_cnt_d      = '0;
    m_addr_d      = m_addr_q;
    m_wdata_d     = m_wdata_q;
    err_timeout_d = err_timeout_q;
    err_overrun_d = err_overrun_q;

    if (w_take) begin
      pending_d[w_grant] = 1'b0;
      grant_d            = w_grant;
      m_addr_d           = src_addr_q[w_grant];
      if (w_grant[0] == SRC_WR) m_wdata_d = wr_data_q[w_gnt_port];
    end

    // Overrun only when a still-waiting request is replaced; a start on the grant edge loses nothing
    for (int s = 0; s < N_SRC; s++) begin
      if (w_start[s]) begin
        if (pending_d[s]) err_overrun_d[s] = 1'b1;
        pending_d[s]  = 1'b1;
        src_addr_d[s] = w_src_addr[s];
      end
    end
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (p_wr_start[p]) wr_data_d[p] = p_wr_data[p*DATA_WIDTH +: DATA_WIDTH];
    end

    if (((state_q == ISSUE) || (state_q == WAIT)) && w_cur_rd && m_rd_done)
      rd_data_d[w_cur_port] = m_rd_data;

    if (state_q == WAIT) begin
      wd_cnt_d = wd_cnt_q + 1'b1;
      if (!w_done && w_timeout) err_timeout_d = 1'b1;
    end

    if (state_q == RESP) last_grant_d = grant_q;
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      pending_q     <= '0;
      src_addr_q    <= '{default: '0};
      wr_data_q     <= '{default: '0};
      rd_data_q     <= '{default: '0};
      grant_q       <= '0;
      last_grant_q  <= IDX_W'(N_SRC - 1);
      wd_cnt_q      <= '0;
      m_addr_q      <= '0;
      m_wdata_q     <= '0;
      err_timeout_q <= 1'b0;
      err_overrun_q <= '0;
    end else begin
      pending_q     <= pending_d;
      src_addr_q    <= src_addr_d;
      wr_data_q     <= wr_data_d;
      rd_data_q     <= rd_data_d;
      grant_q       <= grant_d;
      last_grant_q  <= last_grant_d;
      wd_cnt_q      <= wd_cnt_d;
      m_addr_q      <= m_addr_d;
      m_wdata_q     <= m_wdata_d;
      err_timeout_q <= err_timeout_d;
      err_overrun_q <= err_overrun_d;
    end
  end

  assign m_addr      = m_addr_q;
  assign m_wdata     = m_wdata_q;
  assign err_timeout = err_timeout_q;
  assign err_overrun = err_overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_axi_port_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_axi_port_arbiter : self-checking bench for axi_port_arbiter        |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_axi_port_arbiter;

  localparam int NP = 2;
  localparam int AW = 32;
  localparam int DW = 256;
  localparam int TO = 16;
  localparam int NS = 2 * NP;

  logic              ACLK = 1'b0;
  logic              ARESETN;
  logic [NP-1:0]     p_wr_start, p_rd_start, p_wr_done, p_rd_done;
  logic [NP*AW-1:0]  p_wr_addr, p_rd_addr;
  logic [NP*DW-1:0]  p_wr_data, p_rd_data;
  logic              m_wr_start, m_rd_start, m_wr_done, m_rd_done, busy, err_timeout;
  logic [AW-1:0]     m_addr;
  logic [DW-1:0]     m_wdata, m_rd_data;
  logic [NS-1:0]     err_overrun;

  int n_vec = 0;
  int n_err = 0;

  axi_port_arbiter #(.NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .p_wr_start(p_wr_start), .p_wr_addr(p_wr_addr), .p_wr_data(p_wr_data), .p_wr_done(p_wr_done),
    .p_rd_start(p_rd_start), .p_rd_addr(p_rd_addr), .p_rd_done(p_rd_done), .p_rd_data(p_rd_data),
    .m_wr_start(m_wr_start), .m_rd_start(m_rd_start), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_wr_done(m_wr_done), .m_rd_done(m_rd_done), .m_rd_data(m_rd_data),
    .busy(busy), .err_timeout(err_timeout), .err_overrun(err_overrun)
  );

  always #5 ACLK = ~ACLK;

  function automatic logic [DW-1:0] rand_dw();
    logic [DW-1:0] v;
    for (int i = 0; i < DW / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic clear_inputs();
    p_wr_start = '0; p_rd_start = '0; p_wr_addr = '0; p_rd_addr = '0; p_wr_data = '0;
    m_wr_done = 1'b0; m_rd_done = 1'b0; m_rd_data = '0;
  endtask

  task automatic reset_dut();
    clear_inputs();
    ARESETN = 1'b0;
    repeat (2) @(negedge ACLK);
    ARESETN = 1'b1;
  endtask

  task automatic test_reset();
    reset_dut();
    @(negedge ACLK);
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_vec++; if ({m_wr_start, m_rd_start} !== 2'b00) begin n_err++; $display("FAIL reset_mstart: got %b expected 00", {m_wr_start, m_rd_start}); end
    n_vec++; if (m_addr !== '0 || m_wdata !== '0) begin n_err++; $display("FAIL reset_maddr: got %h expected 0", m_addr); end
    n_vec++; if ({p_wr_done, p_rd_done, err_overrun, err_timeout} !== '0) begin n_err++; $display("FAIL reset_flags: got %h expected 0", {p_wr_done, p_rd_done, err_overrun, err_timeout}); end
    n_vec++; if (p_rd_data !== '0) begin n_err++; $display("FAIL reset_rdata: got %h expected 0", p_rd_data); end
  endtask

  task automatic test_single_write();
    logic [DW-1:0] d;
    d = {32{8'hA5}};
    reset_dut();
    @(negedge ACLK);
    p_wr_addr[0 +: AW] = 32'h0000_1000; p_wr_data[0 +: DW] = d; p_wr_start = 2'b01;
    for (int c = 1; c <= 7; c++) begin
      @(negedge ACLK);
      p_wr_start = '0;
      if (c == 2) begin
        n_vec++; if (m_wr_start !== 1'b1) begin n_err++; $display("FAIL sw_mstart: got %b expected 1", m_wr_start); end
        n_vec++; if (m_addr !== 32'h1000) begin n_err++; $display("FAIL sw_maddr: got %h expected 1000", m_addr); end
        n_vec++; if (m_wdata !== d) begin n_err++; $display("FAIL sw_mwdata: got %h expected %h", m_wdata, d); end
      end
      if (c == 3 || c == 5) begin
        n_vec++; if ({m_wr_start, p_wr_done, busy} !== 4'b0001) begin n_err++; $display("FAIL sw_wait_c%0d: got %b expected 0001", c, {m_wr_start, p_wr_done, busy}); end
      end
      if (c == 6) begin
        n_vec++; if ({p_wr_done, busy} !== 3'b011) begin n_err++; $display("FAIL sw_done: got %b expected 011", {p_wr_done, busy}); end
      end
      if (c == 7) begin
        n_vec++; if ({p_wr_done, busy} !== 3'b000) begin n_err++; $display("FAIL sw_idle: got %b expected 000", {p_wr_done, busy}); end
      end
      m_wr_done = (c == 5);
    end
    m_wr_done = 1'b0;
  endtask

  task automatic test_round_robin();
    logic [AW-1:0] exp_addr [NS];
    int n_iss = 0, n_dn = 0, last_src = 0, due = -1;
    exp_addr = '{32'h100, 32'h200, 32'h300, 32'h400};
    reset_dut();
    @(negedge ACLK);
    p_wr_addr = {exp_addr[2], exp_addr[0]}; p_rd_addr = {exp_addr[3], exp_addr[1]};
    p_wr_start = 2'b11; p_rd_start = 2'b11;
    for (int c = 1; c <= 40; c++) begin
      @(negedge ACLK);
      p_wr_start = '0; p_rd_start = '0;
      if ({p_rd_done, p_wr_done} !== '0) begin
        n_vec++;
        if ({p_rd_done, p_wr_done} !== NS'(1) << ((last_src % 2) * NP + last_src / 2)) begin
          n_err++; $display("FAIL rr_done_src%0d: got %b", last_src, {p_rd_done, p_wr_done});
        end
        n_dn++;
      end
      if (m_wr_start || m_rd_start) begin
        n_vec++;
        if (n_iss >= NS || m_rd_start !== 1'(n_iss % 2) || m_addr !== exp_addr[n_iss % NS]) begin
          n_err++; $display("FAIL rr_grant%0d: got rd=%b addr=%h expected src %0d", n_iss, m_rd_start, m_addr, n_iss);
        end
        last_src = n_iss % NS; n_iss++; due = c + 1;
      end
      m_wr_done = (c == due) && (last_src % 2 == 0);
      m_rd_done = (c == due) && (last_src % 2 == 1);
    end
    n_vec++; if (n_iss != NS || n_dn != NS) begin n_err++; $display("FAIL rr_count: got %0d/%0d expected %0d", n_iss, n_dn, NS); end
  endtask

  task automatic test_read_data();
    int due = -1;
    bit seen = 0;
    reset_dut();
    @(negedge ACLK);
    p_rd_addr[AW +: AW] = 32'h40; p_rd_start = 2'b10;
    for (int c = 1; c <= 12; c++) begin
      @(negedge ACLK);
      p_rd_start = '0;
      if (m_rd_start) begin
        n_vec++; if (m_addr !== 32'h40) begin n_err++; $display("FAIL rd_addr: got %h expected 40", m_addr); end
        due = c + 1;
      end
      if (p_rd_done !== '0) begin
        seen = 1;
        n_vec++; if (p_rd_done !== 2'b10) begin n_err++; $display("FAIL rd_done: got %b expected 10", p_rd_done); end
        n_vec++; if (p_rd_data !== {DW'(32'hDEAD_BEEF), DW'(0)}) begin n_err++; $display("FAIL rd_data: got %h", p_rd_data[DW +: 32]); end
      end
      m_rd_done = (c == due);
      m_rd_data = (c == due) ? DW'(32'hDEAD_BEEF) : rand_dw();
    end
    m_rd_done = 1'b0;
    n_vec++; if (!seen || p_rd_data !== {DW'(32'hDEAD_BEEF), DW'(0)}) begin n_err++; $display("FAIL rd_hold: got %h seen=%b", p_rd_data[DW +: 32], seen); end
  endtask

  // Runs straight after test_read_data so port 1 read data is non-zero going in
  task automatic test_reset_mid_wait();
    int n_bad = 0;
    @(negedge ACLK);
    p_wr_addr = {32'hB0, 32'hA0}; p_wr_data = {rand_dw(), {32{8'h55}}}; p_wr_start = 2'b11;
    repeat (4) begin @(negedge ACLK); p_wr_start = '0; end
    ARESETN = 1'b0;
    #1;
    n_vec++; if ({busy, m_wr_start, m_rd_start, p_wr_done, p_rd_done} !== '0) begin n_err++; $display("FAIL rmw_ctrl: got %b expected 0", {busy, m_wr_start, m_rd_start, p_wr_done, p_rd_done}); end
    n_vec++; if (m_addr !== '0 || m_wdata !== '0 || p_rd_data !== '0) begin n_err++; $display("FAIL rmw_data: got addr %h expected 0", m_addr); end
    @(negedge ACLK);
    ARESETN = 1'b1; m_wr_done = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge ACLK);
      m_wr_done = 1'b0;
      if ({busy, m_wr_start, m_rd_start, p_wr_done, p_rd_done} !== '0) n_bad++;
    end
    n_vec++; if (n_bad != 0) begin n_err++; $display("FAIL rmw_quiet: got %0d active cycles expected 0", n_bad); end
    p_wr_addr = {32'hB0, 32'hA0}; p_wr_start = 2'b11;
    @(negedge ACLK); p_wr_start = '0;
    @(negedge ACLK);
    n_vec++; if (m_wr_start !== 1'b1 || m_addr !== 32'hA0) begin n_err++; $display("FAIL rmw_prio: got %b/%h expected 1/a0", m_wr_start, m_addr); end
  endtask

  task automatic test_timeout();
    reset_dut();
    @(negedge ACLK);
    p_wr_addr[0 +: AW] = 32'h1234; p_wr_start = 2'b01;
    for (int c = 1; c <= 30; c++) begin
      @(negedge ACLK);
      p_wr_start = '0; p_rd_start = '0; m_rd_done = 1'b0;
      if (c == 3) begin p_rd_addr[0 +: AW] = 32'h77; p_rd_start = 2'b01; end
      if (c == 18) begin
        n_vec++; if ({err_timeout, p_wr_done, busy} !== 4'b0001) begin n_err++; $display("FAIL to_before: got %b expected 0001", {err_timeout, p_wr_done, busy}); end
      end
      if (c == 19) begin
        n_vec++; if ({err_timeout, p_wr_done} !== 3'b101) begin n_err++; $display("FAIL to_abort: got %b expected 101", {err_timeout, p_wr_done}); end
      end
      if (c == 21) begin
        n_vec++; if (m_rd_start !== 1'b1 || m_addr !== 32'h77) begin n_err++; $display("FAIL to_next: got %b/%h expected 1/77", m_rd_start, m_addr); end
        m_rd_done = 1'b1;
      end
      if (c == 22) begin
        n_vec++; if (p_rd_done !== 2'b01) begin n_err++; $display("FAIL to_next_done: got %b expected 01", p_rd_done); end
      end
    end
    n_vec++; if (err_timeout !== 1'b1) begin n_err++; $display("FAIL to_sticky: got %b expected 1", err_timeout); end
  endtask

  task automatic test_overrun();
    int n_rd1 = 0;
    reset_dut();
    @(negedge ACLK);
    p_rd_addr[AW +: AW] = 32'h80; p_rd_start = 2'b10;
    for (int c = 1; c <= 20; c++) begin
      @(negedge ACLK);
      p_rd_start = '0; m_rd_done = 1'b0;
      if (c == 4) begin p_rd_addr[0 +: AW] = 32'h10; p_rd_start = 2'b01; end
      if (c == 5) begin p_rd_addr[0 +: AW] = 32'h20; p_rd_start = 2'b01; end
      if (c == 8) m_rd_done = 1'b1;
      if (c >= 10 && m_rd_start) n_rd1++;
      if (c == 11) begin
        n_vec++; if (m_rd_start !== 1'b1 || m_addr !== 32'h20) begin n_err++; $display("FAIL ov_issue: got %b/%h expected 1/20", m_rd_start, m_addr); end
        m_rd_done = 1'b1;
      end
      if (c == 12) begin
        n_vec++; if (p_rd_done !== 2'b01) begin n_err++; $display("FAIL ov_done: got %b expected 01", p_rd_done); end
      end
    end
    n_vec++; if (err_overrun !== 4'b0010) begin n_err++; $display("FAIL ov_flag: got %b expected 0010", err_overrun); end
    n_vec++; if (n_rd1 != 1) begin n_err++; $display("FAIL ov_single: got %0d reads expected 1", n_rd1); end
  endtask

  // Reference: pending set, captured requests, rr search, transaction timing from the latency rules
  task automatic test_random();
    bit [NS-1:0]   pend = '0, ovr = '0;
    logic [AW-1:0] cap_a [NS];
    logic [DW-1:0] cap_d [NS];
    logic [DW-1:0] exp_rd [NP];
    logic [AW-1:0] cur_a = '0;
    logic [DW-1:0] cur_d = '0;
    logic [NP*DW-1:0] exp_flat;
    logic [2*NP-1:0]  exp_dn;
    int last = NS - 1, free_at = 0, iss = -10, dn = -10, cur = 0, g;
    bit st;
    reset_dut();
    for (int p = 0; p < NP; p++) exp_rd[p] = '0;
    for (int c = 0; c < 1500; c++) begin
      @(negedge ACLK);
      exp_dn = (c == dn + 1) ? (2*NP)'(1) << ((cur % 2) * NP + cur / 2) : '0;
      for (int p = 0; p < NP; p++) exp_flat[p*DW +: DW] = exp_rd[p];
      n_vec++;
      if ({m_wr_start, m_rd_start} !== {c == iss && cur % 2 == 0, c == iss && cur % 2 == 1} ||
          busy !== (c >= iss && c <= dn + 1) || {p_rd_done, p_wr_done} !== exp_dn) begin
        n_err++; $display("FAIL rnd_ctrl c%0d: got ws=%b rs=%b busy=%b dn=%b expected src %0d iss %0d done %0d", c, m_wr_start, m_rd_start, busy, {p_rd_done, p_wr_done}, cur, iss, dn);
      end
      n_vec++;
      if (m_addr !== cur_a || m_wdata !== cur_d || p_rd_data !== exp_flat) begin
        n_err++; $display("FAIL rnd_data c%0d: got addr %h expected %h", c, m_addr, cur_a);
      end
      m_wr_done = (c == dn) && (cur % 2 == 0);
      m_rd_done = (c == dn) && (cur % 2 == 1);
      if (c >= iss && c < dn && $urandom_range(0, 3) == 0) begin
        if (cur % 2 == 0) m_rd_done = 1'b1; else m_wr_done = 1'b1;
      end
      m_rd_data = rand_dw();
      if (c == dn && cur % 2 == 1) exp_rd[cur / 2] = m_rd_data;
      if (c >= free_at && pend != '0) begin
        g = -1;
        for (int i = 1; i <= NS && g < 0; i++) if (pend[(last + i) % NS]) g = (last + i) % NS;
        pend[g] = 1'b0; cur = g; last = g; cur_a = cap_a[g];
        if (g % 2 == 0) cur_d = cap_d[g];
        iss = c + 1; dn = iss + $urandom_range(0, 3); free_at = dn + 2;
      end
      for (int s = 0; s < NS; s++) begin
        st = ($urandom_range(0, 7) == 0);
        cap_a[s] = st ? $urandom : cap_a[s];
        if (s % 2 == 0) begin
          p_wr_start[s/2] = st;
          p_wr_addr[(s/2)*AW +: AW] = st ? cap_a[s] : $urandom;
          if (st) cap_d[s] = rand_dw();
          p_wr_data[(s/2)*DW +: DW] = st ? cap_d[s] : rand_dw();
        end else begin
          p_rd_start[s/2] = st;
          p_rd_addr[(s/2)*AW +: AW] = st ? cap_a[s] : $urandom;
        end
        if (st) begin
          if (pend[s]) ovr[s] = 1'b1;
          pend[s] = 1'b1;
        end
      end
    end
    @(negedge ACLK);
    clear_inputs();
    n_vec++; if (err_overrun !== ovr || err_timeout !== 1'b0) begin n_err++; $display("FAIL rnd_err: got %b/%b expected %b/0", err_overrun, err_timeout, ovr); end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_round_robin();
    test_read_data();
    test_reset_mid_wait();
    test_timeout();
    test_overrun();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
